// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - bus bundle for reg_file_mp: read ports, two write ports, clear handshake
interface reg_file_mp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD*ADDR_W-1:0] rdAddr;
  logic [NUM_RD*DATA_W-1:0] rdData;
  logic                     wrEn0;
  logic [ADDR_W-1:0]        wrAddr0;
  logic [DATA_W-1:0]        wrData0;
  logic                     wrEn1;
  logic [ADDR_W-1:0]        wrAddr1;
  logic [DATA_W-1:0]        wrData1;
  logic                     clearReq;
  logic                     ready;
  logic                     wrConflict;

  modport master (
    output rdAddr, wrEn0, wrAddr0, wrData0, wrEn1, wrAddr1, wrData1, clearReq,
    input  rdData, ready, wrConflict
  );

  modport slave (
    input  rdAddr, wrEn0, wrAddr0, wrData0, wrEn1, wrAddr1, wrData1, clearReq,
    output rdData, ready, wrConflict
  );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with 2 prioritised write ports and clear sweep (optional REGFILE_BYPASS_EN forwarding)
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic                     ready;
  logic                     wr0_ok;
  logic                     wr1_ok;
  logic                     conflict;
  logic [NUM_RD*DATA_W-1:0] rd_data;

  // An address holds real storage if it is in range and is not the hardwired zero register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign ready = (state_q == ST_IDLE);

  // A write commits only when the file is idle and the target is live storage.
  always_comb begin
    wr0_ok   = ready && bus.wrEn0 && addr_live(bus.wrAddr0);
    wr1_ok   = ready && bus.wrEn1 && addr_live(bus.wrAddr1);
    conflict = wr0_ok && wr1_ok && (bus.wrAddr0 == bus.wrAddr1);
  end

  // Clear-engine FSM: one entry per cycle from clr_ptr 0 up to the last register.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clearReq) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_ptr_q == LAST_IDX) begin
          clr_ptr_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next register contents: port 1, then port 0 on top so it wins, then the sweep.
  always_comb begin
    regs_d        = regs_q;
    wr_conflict_d = conflict;
    if (wr1_ok && !conflict) regs_d[bus.wrAddr1] = bus.wrData1;
    if (wr0_ok)              regs_d[bus.wrAddr0] = bus.wrData0;
    if (state_q == ST_CLEAR) regs_d[clr_ptr_q]   = '0;
  end

  // State, storage and conflict flag; reset wipes everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      clr_ptr_q     <= '0;
      wr_conflict_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wr_conflict_q <= wr_conflict_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = bus.rdAddr[k*ADDR_W +: ADDR_W];

    // Read port k: stored value, zero for dead addresses, optionally forwarded write data.
    always_comb begin
      rv = '0;
      if (addr_live(ra)) begin
        rv = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr0_ok && (bus.wrAddr0 == ra)) begin
          rv = bus.wrData0;
        end else if (wr1_ok && !conflict && (bus.wrAddr1 == ra)) begin
          rv = bus.wrData1;
        end
`endif
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rv;
  end

  assign bus.rdData     = rd_data;
  assign bus.ready      = ready;
  assign bus.wrConflict = wr_conflict_q;
endmodule
